// File: rtl/lsu_pkg.sv
// Shared LSU definitions: load/store FSM state encodings and the core
// pipeline state enum that the scheduler drives into every thread's LSU.
package lsu_pkg;

  // LSU handshake FSM; lsu_state exposes these codes to the scheduler.
  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // Core pipeline state, shared by scheduler, register file, ALU and LSU.
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  // True while a memory request is outstanding.
  function automatic logic lsu_busy(input lsu_state_e s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// LSU watchdog: counts enabled cycles spent with a request outstanding and
// flags expiry on the cycle whose edge would reach TIMEOUT_CYCLES.
// Only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic busy_i,
  output logic expire_o
);

  localparam int CNT_BITS = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  logic [CNT_BITS-1:0] cnt_q;

  // Expiry is combinational so the FSM can leave on the limiting edge itself.
  assign expire_o = busy_i && (cnt_q == LAST);

  // Count busy cycles while the thread is enabled; clear whenever idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!busy_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expire_o) begin
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/lsu.sv
// Per-thread load/store unit. Issues one read (LDR) or write (STR) to the
// memory controller with a valid/ready handshake and reports progress on
// lsu_state so the scheduler can hold the core in WAIT.
// Optional watchdog: define LSU_TIMEOUT_EN to abort requests after
// TIMEOUT_CYCLES cycles without ready (sets lsu_error, returns 0).
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [7:0]           rs,
  input  logic [7:0]           rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_e           state_q;
  logic                 read_valid_q;
  logic                 write_valid_q;
  logic [ADDR_BITS-1:0] read_addr_q;
  logic [ADDR_BITS-1:0] write_addr_q;
  logic [DATA_BITS-1:0] write_data_q;
  logic [DATA_BITS-1:0] out_q;
  logic                 ready_hit;
  logic                 timeout;

  // Only the ready matching the outstanding request counts; stray readies
  // (wrong direction, or while no valid is up) fall out here.
  assign ready_hit = (read_valid_q & mem_read_ready) | (write_valid_q & mem_write_ready);

`ifdef LSU_TIMEOUT_EN
  logic error_q;

  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable_i(enable),
    .busy_i  (lsu_busy(state_q)),
    .expire_o(timeout)
  );

  // Error is sticky from the timeout edge until the core's UPDATE step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (enable) begin
      if (lsu_busy(state_q) && !ready_hit && timeout) begin
        error_q <= 1'b1;
      end else if (state_q == LSU_DONE && core_state == CORE_UPDATE) begin
        error_q <= 1'b0;
      end
    end
  end

  assign lsu_error = error_q;
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
  assign lsu_error          = 1'b0;
`endif

  // Handshake FSM with registered request outputs and load result.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LSU_IDLE;
      read_valid_q  <= 1'b0;
      write_valid_q <= 1'b0;
      read_addr_q   <= '0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      out_q         <= '0;
    end else if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST) begin
            if (decoded_mem_read_enable) begin
              // A load wins when both enables are set.
              read_valid_q <= 1'b1;
              read_addr_q  <= rs[ADDR_BITS-1:0];
              state_q      <= LSU_REQUESTING;
            end else if (decoded_mem_write_enable) begin
              write_valid_q <= 1'b1;
              write_addr_q  <= rs[ADDR_BITS-1:0];
              write_data_q  <= DATA_BITS'(rt);
              state_q       <= LSU_REQUESTING;
            end
          end
        end
        LSU_REQUESTING, LSU_WAITING: begin
          if (ready_hit) begin
            if (read_valid_q) out_q <= mem_read_data;
            read_valid_q  <= 1'b0;
            write_valid_q <= 1'b0;
            state_q       <= LSU_DONE;
          end else if (timeout) begin
            read_valid_q  <= 1'b0;
            write_valid_q <= 1'b0;
            out_q         <= '0;
            state_q       <= LSU_DONE;
          end else if (state_q == LSU_REQUESTING) begin
            state_q <= LSU_WAITING;
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) state_q <= LSU_IDLE;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign lsu_state         = state_q;
  assign mem_read_valid    = read_valid_q;
  assign mem_read_address  = read_addr_q;
  assign mem_write_valid   = write_valid_q;
  assign mem_write_address = write_addr_q;
  assign mem_write_data    = write_data_q;
  assign lsu_out           = out_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the LSU handshake FSM.
// Build with +define+LSU_TIMEOUT_EN to exercise the watchdog path.
module tb_lsu;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int vectors = 0;
  int miscompares = 0;

  lsu #(.DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .core_state              (core_state),
    .decoded_mem_read_enable (rd_en),
    .decoded_mem_write_enable(wr_en),
    .rs                      (rs),
    .rt                      (rt),
    .mem_read_valid          (mem_read_valid),
    .mem_read_address        (mem_read_address),
    .mem_read_ready          (mem_read_ready),
    .mem_read_data           (mem_read_data),
    .mem_write_valid         (mem_write_valid),
    .mem_write_address       (mem_write_address),
    .mem_write_data          (mem_write_data),
    .mem_write_ready         (mem_write_ready),
    .lsu_state               (lsu_state),
    .lsu_out                 (lsu_out),
    .lsu_error               (lsu_error)
  );

  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1);
  end

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_state      = CORE_WAIT;
    rd_en           = 1'b0;
    wr_en           = 1'b0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; rs = 8'h00; rt = 8'h00; mem_read_data = 8'h00;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({lsu_state, mem_read_valid, mem_write_valid, lsu_error} !== 5'b00_0_0_0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {lsu_state, mem_read_valid, mem_write_valid, lsu_error});
    end
    vectors++;
    if ({mem_read_address, mem_write_address, mem_write_data, lsu_out} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 00000000",
               {mem_read_address, mem_write_address, mem_write_data, lsu_out});
    end
  endtask

  // LDR rs=0x10, ready arrives on the third edge after valid, data 0xA5.
  task automatic test_load();
    core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h10;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0; rs = 8'hFF;
    vectors++;
    if ({lsu_state, mem_read_valid, mem_write_valid, mem_read_address} !== {2'b01, 2'b10, 8'h10}) begin
      miscompares++;
      $display("FAIL load_issue: got st=%b rv=%b wv=%b a=%h want 01 1 0 10",
               lsu_state, mem_read_valid, mem_write_valid, mem_read_address);
    end
    tick(); tick();
    vectors++;
    if ({lsu_state, mem_read_valid, mem_read_address} !== {2'b10, 1'b1, 8'h10}) begin
      miscompares++;
      $display("FAIL load_wait: got st=%b rv=%b a=%h want 10 1 10",
               lsu_state, mem_read_valid, mem_read_address);
    end
    mem_read_ready = 1'b1; mem_read_data = 8'hA5;
    tick();
    mem_read_ready = 1'b0;
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_out, lsu_error} !== {2'b11, 1'b0, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("FAIL load_done: got st=%b rv=%b out=%h err=%b want 11 0 a5 0",
               lsu_state, mem_read_valid, lsu_out, lsu_error);
    end
    // A ready in DONE must be ignored.
    mem_read_ready = 1'b1; mem_read_data = 8'h77;
    tick();
    mem_read_ready = 1'b0;
    vectors++;
    if ({lsu_state, lsu_out} !== {2'b11, 8'hA5}) begin
      miscompares++;
      $display("FAIL load_done_stray: got st=%b out=%h want 11 a5", lsu_state, lsu_out);
    end
    core_state = CORE_UPDATE;
    tick();
    core_state = CORE_WAIT;
    vectors++;
    if ({lsu_state, lsu_out} !== {2'b00, 8'hA5}) begin
      miscompares++;
      $display("FAIL load_update: got st=%b out=%h want 00 a5", lsu_state, lsu_out);
    end
  endtask

  // STR rs=0x20 rt=0x3C with ready in REQUESTING: minimum latency.
  task automatic test_store();
    core_state = CORE_REQUEST; wr_en = 1'b1; rs = 8'h20; rt = 8'h3C;
    tick();
    core_state = CORE_WAIT; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
    vectors++;
    if ({lsu_state, mem_write_valid, mem_read_valid, mem_write_address, mem_write_data}
        !== {2'b01, 2'b10, 8'h20, 8'h3C}) begin
      miscompares++;
      $display("FAIL store_issue: got st=%b wv=%b rv=%b a=%h d=%h want 01 1 0 20 3c",
               lsu_state, mem_write_valid, mem_read_valid, mem_write_address, mem_write_data);
    end
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    vectors++;
    if ({lsu_state, mem_write_valid, lsu_out} !== {2'b11, 1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL store_done: got st=%b wv=%b out=%h want 11 0 a5",
               lsu_state, mem_write_valid, lsu_out);
    end
    core_state = CORE_UPDATE;
    tick();
    core_state = CORE_WAIT;
    vectors++;
    if (lsu_state !== 2'b00) begin
      miscompares++;
      $display("FAIL store_update: got st=%b want 00", lsu_state);
    end
  endtask

  // Both enables: read wins, write-ready for a read request is ignored.
  task automatic test_both_enables();
    core_state = CORE_REQUEST; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h33; rt = 8'h44;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0; wr_en = 1'b0;
    vectors++;
    if ({mem_read_valid, mem_write_valid, mem_read_address} !== {2'b10, 8'h33}) begin
      miscompares++;
      $display("FAIL both_issue: got rv=%b wv=%b a=%h want 1 0 33",
               mem_read_valid, mem_write_valid, mem_read_address);
    end
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    vectors++;
    if ({lsu_state, mem_read_valid, mem_write_valid} !== {2'b10, 2'b10}) begin
      miscompares++;
      $display("FAIL both_stray_ready: got st=%b rv=%b wv=%b want 10 1 0",
               lsu_state, mem_read_valid, mem_write_valid);
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h5A;
    tick();
    mem_read_ready = 1'b0;
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_out} !== {2'b11, 1'b0, 8'h5A}) begin
      miscompares++;
      $display("FAIL both_done: got st=%b rv=%b out=%h want 11 0 5a",
               lsu_state, mem_read_valid, lsu_out);
    end
    core_state = CORE_UPDATE;
    tick();
    core_state = CORE_WAIT;
  endtask

  // enable=0 blocks issue, freezes an outstanding request and DONE.
  task automatic test_enable_hold();
    enable = 1'b0; core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h61;
    tick(); tick();
    vectors++;
    if ({lsu_state, mem_read_valid} !== 3'b00_0) begin
      miscompares++;
      $display("FAIL en0_no_issue: got st=%b rv=%b want 00 0", lsu_state, mem_read_valid);
    end
    enable = 1'b1;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0;
    enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h99;
    tick(); tick();
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_out} !== {2'b01, 1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL en0_hold_req: got st=%b rv=%b out=%h want 01 1 5a",
               lsu_state, mem_read_valid, lsu_out);
    end
    enable = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    vectors++;
    if ({lsu_state, lsu_out} !== {2'b11, 8'h99}) begin
      miscompares++;
      $display("FAIL en1_complete: got st=%b out=%h want 11 99", lsu_state, lsu_out);
    end
    enable = 1'b0; core_state = CORE_UPDATE;
    tick();
    vectors++;
    if (lsu_state !== 2'b11) begin
      miscompares++;
      $display("FAIL en0_hold_done: got st=%b want 11", lsu_state);
    end
    enable = 1'b1;
    tick();
    core_state = CORE_WAIT;
    vectors++;
    if (lsu_state !== 2'b00) begin
      miscompares++;
      $display("FAIL en1_update: got st=%b want 00", lsu_state);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  // TIMEOUT_CYCLES=4, load with no ready: DONE on the 4th busy edge.
  task automatic test_timeout();
    core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h40;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_error, lsu_out} !== {2'b10, 2'b10, 8'h99}) begin
      miscompares++;
      $display("FAIL to_pending: got st=%b rv=%b err=%b out=%h want 10 1 0 99",
               lsu_state, mem_read_valid, lsu_error, lsu_out);
    end
    tick();
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_error, lsu_out} !== {2'b11, 2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL to_expire: got st=%b rv=%b err=%b out=%h want 11 0 1 00",
               lsu_state, mem_read_valid, lsu_error, lsu_out);
    end
    tick();
    vectors++;
    if ({lsu_state, lsu_error} !== 3'b11_1) begin
      miscompares++;
      $display("FAIL to_sticky: got st=%b err=%b want 11 1", lsu_state, lsu_error);
    end
    core_state = CORE_UPDATE;
    tick();
    core_state = CORE_WAIT;
    vectors++;
    if ({lsu_state, lsu_error} !== 3'b00_0) begin
      miscompares++;
      $display("FAIL to_clear: got st=%b err=%b want 00 0", lsu_state, lsu_error);
    end
    // Leave a nonzero lsu_out for the reset test.
    core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h41;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0;
    mem_read_ready = 1'b1; mem_read_data = 8'h11;
    tick();
    mem_read_ready = 1'b0;
    core_state = CORE_UPDATE;
    tick();
    core_state = CORE_WAIT;
  endtask
`else
  // Without the watchdog the LSU waits indefinitely with no error.
  task automatic test_no_timeout();
    core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h40;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_error} !== 4'b10_1_0) begin
      miscompares++;
      $display("FAIL nto_wait: got st=%b rv=%b err=%b want 10 1 0",
               lsu_state, mem_read_valid, lsu_error);
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h11;
    tick();
    mem_read_ready = 1'b0;
    vectors++;
    if ({lsu_state, lsu_out, lsu_error} !== {2'b11, 8'h11, 1'b0}) begin
      miscompares++;
      $display("FAIL nto_done: got st=%b out=%h err=%b want 11 11 0",
               lsu_state, lsu_out, lsu_error);
    end
    core_state = CORE_UPDATE;
    tick();
    core_state = CORE_WAIT;
  endtask
`endif

  // Reset pulsed in WAITING clears outputs before the next clock edge.
  task automatic test_reset_mid();
    core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h70;
    tick();
    core_state = CORE_WAIT; rd_en = 1'b0;
    tick();
    vectors++;
    if ({lsu_state, mem_read_valid, lsu_out} !== {2'b10, 1'b1, 8'h11}) begin
      miscompares++;
      $display("FAIL rmid_pre: got st=%b rv=%b out=%h want 10 1 11",
               lsu_state, mem_read_valid, lsu_out);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({lsu_state, mem_read_valid, mem_read_address, lsu_out, lsu_error}
        !== {2'b00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL rmid_async: got st=%b rv=%b a=%h out=%h err=%b want 00 0 00 00 0",
               lsu_state, mem_read_valid, mem_read_address, lsu_out, lsu_error);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if ({lsu_state, mem_read_valid} !== 3'b00_0) begin
      miscompares++;
      $display("FAIL rmid_post: got st=%b rv=%b want 00 0", lsu_state, mem_read_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_both_enables();
    test_enable_hold();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
